// File: rtl/arm_ctrl_exmem.sv
// LEGv8 control slice: main and ALU-control decoders feeding EX,
// plus the EX/MEM pipeline register for memory/writeback controls.
module arm_ctrl_exmem #(
  parameter int DW = 64,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   opcode,
  input  logic          sign,
  output logic          uncondBr,
  output logic          branch,
  output logic          Reg2Loc,
  output logic          ALU_Src,
  output logic          RegWrite,
  output logic          ALU_SH,
  output logic          Imm,
  output logic          memToReg,
  output logic          memWrite,
  output logic          memRead,
  output logic          shiftDirn,
  output logic          ALU_on,
  output logic          set_flags,
  output logic          branchReg,
  output logic          branchLink,
  output logic          IF_ID_flush,
  output logic [1:0]    fwdEn,
  output logic [2:0]    ALU_cntrl,
  input  logic          memToReg_EX,
  input  logic          memWrite_EX,
  input  logic          memRead_EX,
  input  logic          branchLink_EX,
  input  logic          RegWrite_EX,
  input  logic [RW-1:0] targetReg_EX,
  input  logic [DW-1:0] toDataMem,
  input  logic [DW-1:0] ALU_B,
  output logic          memToReg_MEM,
  output logic          memWrite_MEM,
  output logic          memRead_MEM,
  output logic          branchLink_MEM,
  output logic          RegWrite_MEM,
  output logic [RW-1:0] targetReg_MEM,
  output logic [DW-1:0] toDataMem_MEM,
  output logic [DW-1:0] ALU_B_MEM
);

  typedef enum logic [3:0] {
    I_NOP, I_ADDS, I_SUBS, I_AND, I_EOR,
    I_LSR, I_LSL, I_LDUR, I_STUR, I_BR,
    I_ADDI, I_CBZ, I_BCOND, I_B, I_BL
  } instr_e;

  typedef struct packed {
    logic       ub;
    logic       br;
    logic       r2l;
    logic       src;
    logic       rw;
    logic       sh;
    logic       imm;
    logic       m2r;
    logic       mw;
    logic       mr;
    logic       dir;
    logic       on;
    logic       sf;
    logic       breg;
    logic       bl;
    logic       fl;
    logic [1:0] fwd;
    logic [2:0] alu;
  } ctrl_t;

  instr_e ins;
  ctrl_t  c;
  ctrl_t  cg;

  // Later matches override earlier ones, so longer opcodes win.
  always_comb begin
    ins = I_NOP;
    case (opcode[10:5])
      6'b000101: ins = I_B;
      6'b100101: ins = I_BL;
      default:   ;
    endcase
    case (opcode[10:3])
      8'b10110100: ins = I_CBZ;
      8'b01010100: ins = I_BCOND;
      default:     ;
    endcase
    if (opcode[10:1] == 10'b1001000100)
      ins = I_ADDI;
    case (opcode)
      11'b10101011000: ins = I_ADDS;
      11'b11101011000: ins = I_SUBS;
      11'b10001010000: ins = I_AND;
      11'b11001010000: ins = I_EOR;
      11'b11010011010: ins = I_LSR;
      11'b11010011011: ins = I_LSL;
      11'b11111000010: ins = I_LDUR;
      11'b11111000000: ins = I_STUR;
      11'b11010110000: ins = I_BR;
      default:         ;
    endcase
  end

  always_comb begin
    c = '0;
    case (ins)
      I_ADDS, I_SUBS, I_AND, I_EOR: begin
        c.r2l = 1'b1;
        c.rw  = 1'b1;
        c.on  = 1'b1;
        c.sf  = (ins == I_ADDS) || (ins == I_SUBS);
        c.fwd = 2'b11;
      end
      I_LSL, I_LSR: begin
        c.r2l = 1'b1;
        c.rw  = 1'b1;
        c.sh  = 1'b1;
        c.dir = (ins == I_LSR);
        c.fwd = 2'b11;
      end
      I_ADDI: begin
        c.src = 1'b1;
        c.imm = 1'b1;
        c.rw  = 1'b1;
        c.on  = 1'b1;
        c.fwd = 2'b10;
      end
      I_LDUR: begin
        c.src = 1'b1;
        c.rw  = 1'b1;
        c.m2r = 1'b1;
        c.mr  = 1'b1;
        c.on  = 1'b1;
      end
      I_STUR: begin
        c.src = 1'b1;
        c.mw  = 1'b1;
        c.on  = 1'b1;
      end
      I_CBZ: begin
        c.br = 1'b1;
        c.on = 1'b1;
        c.fl = 1'b1;
      end
      I_BCOND: begin
        c.br = 1'b1;
        c.fl = 1'b1;
      end
      I_B: begin
        c.ub = 1'b1;
        c.br = 1'b1;
        c.fl = 1'b1;
      end
      I_BL: begin
        c.ub = 1'b1;
        c.br = 1'b1;
        c.bl = 1'b1;
        c.rw = 1'b1;
        c.on = 1'b1;
        c.fl = 1'b1;
      end
      I_BR: begin
        c.ub   = 1'b1;
        c.br   = 1'b1;
        c.breg = 1'b1;
        c.fl   = 1'b1;
      end
      default: ;
    endcase
    // Negative offsets make the address computation a subtract.
    case (ins)
      I_ADDS, I_ADDI: c.alu = 3'b010;
      I_SUBS:         c.alu = 3'b011;
      I_AND:          c.alu = 3'b100;
      I_EOR:          c.alu = 3'b110;
      I_LDUR, I_STUR: c.alu = sign ? 3'b011 : 3'b010;
      default:        c.alu = 3'b000;
    endcase
  end

  assign cg = rst ? c : '0;

  assign uncondBr    = cg.ub;
  assign branch      = cg.br;
  assign Reg2Loc     = cg.r2l;
  assign ALU_Src     = cg.src;
  assign RegWrite    = cg.rw;
  assign ALU_SH      = cg.sh;
  assign Imm         = cg.imm;
  assign memToReg    = cg.m2r;
  assign memWrite    = cg.mw;
  assign memRead     = cg.mr;
  assign shiftDirn   = cg.dir;
  assign ALU_on      = cg.on;
  assign set_flags   = cg.sf;
  assign branchReg   = cg.breg;
  assign branchLink  = cg.bl;
  assign IF_ID_flush = cg.fl;
  assign fwdEn       = cg.fwd;
  assign ALU_cntrl   = cg.alu;

  logic [4:0]    ctl_q;
  logic [RW-1:0] tgt_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] stb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q <= '0;
      tgt_q <= '0;
      res_q <= '0;
      stb_q <= '0;
    end else begin
      ctl_q <= {memToReg_EX, memWrite_EX, memRead_EX,
                branchLink_EX, RegWrite_EX};
      tgt_q <= targetReg_EX;
      res_q <= toDataMem;
      stb_q <= ALU_B;
    end
  end

  assign {memToReg_MEM, memWrite_MEM, memRead_MEM,
          branchLink_MEM, RegWrite_MEM} = ctl_q;
  assign targetReg_MEM = tgt_q;
  assign toDataMem_MEM = res_q;
  assign ALU_B_MEM     = stb_q;

endmodule

// File: tb/tb_arm_ctrl_exmem.sv
// Bench for arm_ctrl_exmem: table-driven decode model and a
// one-deep EX/MEM model, directed cases then random traffic.
module tb_arm_ctrl_exmem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] opcode = '0;
  logic        sign = 1'b0;
  logic        uncondBr, branch, Reg2Loc, ALU_Src, RegWrite;
  logic        ALU_SH, Imm, memToReg, memWrite, memRead;
  logic        shiftDirn, ALU_on, set_flags, branchReg;
  logic        branchLink, IF_ID_flush;
  logic [1:0]  fwdEn;
  logic [2:0]  ALU_cntrl;
  logic        memToReg_EX = 0, memWrite_EX = 0, memRead_EX = 0;
  logic        branchLink_EX = 0, RegWrite_EX = 0;
  logic [4:0]  targetReg_EX = '0;
  logic [63:0] toDataMem = '0, ALU_B = '0;
  logic        memToReg_MEM, memWrite_MEM, memRead_MEM;
  logic        branchLink_MEM, RegWrite_MEM;
  logic [4:0]  targetReg_MEM;
  logic [63:0] toDataMem_MEM, ALU_B_MEM;

  int checks = 0;
  int errors = 0;

  arm_ctrl_exmem #(.DW(64), .RW(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .sign(sign),
    .uncondBr(uncondBr), .branch(branch), .Reg2Loc(Reg2Loc),
    .ALU_Src(ALU_Src), .RegWrite(RegWrite), .ALU_SH(ALU_SH),
    .Imm(Imm), .memToReg(memToReg), .memWrite(memWrite),
    .memRead(memRead), .shiftDirn(shiftDirn), .ALU_on(ALU_on),
    .set_flags(set_flags), .branchReg(branchReg),
    .branchLink(branchLink), .IF_ID_flush(IF_ID_flush),
    .fwdEn(fwdEn), .ALU_cntrl(ALU_cntrl),
    .memToReg_EX(memToReg_EX), .memWrite_EX(memWrite_EX),
    .memRead_EX(memRead_EX), .branchLink_EX(branchLink_EX),
    .RegWrite_EX(RegWrite_EX), .targetReg_EX(targetReg_EX),
    .toDataMem(toDataMem), .ALU_B(ALU_B),
    .memToReg_MEM(memToReg_MEM), .memWrite_MEM(memWrite_MEM),
    .memRead_MEM(memRead_MEM), .branchLink_MEM(branchLink_MEM),
    .RegWrite_MEM(RegWrite_MEM), .targetReg_MEM(targetReg_MEM),
    .toDataMem_MEM(toDataMem_MEM), .ALU_B_MEM(ALU_B_MEM)
  );

  always #5 clk = ~clk;

  localparam int K_NOP = 0, K_ADDS = 1, K_SUBS = 2, K_AND = 3;
  localparam int K_EOR = 4, K_LSR = 5, K_LSL = 6, K_LDUR = 7;
  localparam int K_STUR = 8, K_BR = 9, K_ADDI = 10, K_CBZ = 11;
  localparam int K_BC = 12, K_B = 13, K_BL = 14;

  logic [10:0] t_pat [14];
  int          t_len [14];
  int          t_kind[14];

  initial begin
    t_pat[0]  = 11'b10101011000; t_len[0]  = 11; t_kind[0]  = K_ADDS;
    t_pat[1]  = 11'b11101011000; t_len[1]  = 11; t_kind[1]  = K_SUBS;
    t_pat[2]  = 11'b10001010000; t_len[2]  = 11; t_kind[2]  = K_AND;
    t_pat[3]  = 11'b11001010000; t_len[3]  = 11; t_kind[3]  = K_EOR;
    t_pat[4]  = 11'b11010011010; t_len[4]  = 11; t_kind[4]  = K_LSR;
    t_pat[5]  = 11'b11010011011; t_len[5]  = 11; t_kind[5]  = K_LSL;
    t_pat[6]  = 11'b11111000010; t_len[6]  = 11; t_kind[6]  = K_LDUR;
    t_pat[7]  = 11'b11111000000; t_len[7]  = 11; t_kind[7]  = K_STUR;
    t_pat[8]  = 11'b11010110000; t_len[8]  = 11; t_kind[8]  = K_BR;
    t_pat[9]  = 11'b10010001000; t_len[9]  = 10; t_kind[9]  = K_ADDI;
    t_pat[10] = 11'b10110100000; t_len[10] = 8;  t_kind[10] = K_CBZ;
    t_pat[11] = 11'b01010100000; t_len[11] = 8;  t_kind[11] = K_BC;
    t_pat[12] = 11'b00010100000; t_len[12] = 6;  t_kind[12] = K_B;
    t_pat[13] = 11'b10010100000; t_len[13] = 6;  t_kind[13] = K_BL;
  end

  // Order: ub br r2l src rw sh imm m2r mw mr dir on sf breg bl fl fwd alu
  function automatic logic [20:0] model_dec(logic [10:0] op, logic sg,
                                            logic rs);
    int k = K_NOP;
    int lens[4] = '{11, 10, 8, 6};
    logic ub = 0, br = 0, r2l = 0, src = 0, rw = 0, sh = 0, imm = 0;
    logic m2r = 0, mw = 0, mr = 0, dir = 0, on = 0, sf = 0;
    logic breg = 0, bl = 0, fl = 0;
    logic [1:0] fwd = 0;
    logic [2:0] alu = 0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 14; i++)
        if (k == K_NOP && t_len[i] == lens[p] &&
            (op >> (11 - lens[p])) == (t_pat[i] >> (11 - lens[p])))
          k = t_kind[i];
    if (!rs) k = K_NOP;
    if (k inside {K_ADDS, K_SUBS, K_AND, K_EOR, K_LSL, K_LSR}) begin
      r2l = 1; rw = 1; fwd = 2'b11;
    end
    if (k inside {K_ADDS, K_SUBS, K_AND, K_EOR}) on = 1;
    if (k inside {K_ADDS, K_SUBS}) sf = 1;
    if (k inside {K_LSL, K_LSR}) sh = 1;
    if (k == K_LSR) dir = 1;
    if (k inside {K_ADDI, K_LDUR, K_STUR}) begin src = 1; on = 1; end
    if (k == K_ADDI) begin imm = 1; rw = 1; fwd = 2'b10; end
    if (k == K_LDUR) begin rw = 1; m2r = 1; mr = 1; end
    if (k == K_STUR) mw = 1;
    if (k inside {K_CBZ, K_BC, K_B, K_BL, K_BR}) begin br = 1; fl = 1; end
    if (k inside {K_B, K_BL, K_BR}) ub = 1;
    if (k inside {K_CBZ, K_BL}) on = 1;
    if (k == K_BL) begin bl = 1; rw = 1; end
    if (k == K_BR) breg = 1;
    if (on) begin
      if (k inside {K_ADDS, K_ADDI}) alu = 3'b010;
      else if (k == K_SUBS) alu = 3'b011;
      else if (k == K_AND) alu = 3'b100;
      else if (k == K_EOR) alu = 3'b110;
      else if (k inside {K_LDUR, K_STUR}) alu = sg ? 3'b011 : 3'b010;
    end
    return {ub, br, r2l, src, rw, sh, imm, m2r, mw, mr, dir, on, sf,
            breg, bl, fl, fwd, alu};
  endfunction

  logic [20:0] dec_act;
  assign dec_act = {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite,
                    ALU_SH, Imm, memToReg, memWrite, memRead,
                    shiftDirn, ALU_on, set_flags, branchReg,
                    branchLink, IF_ID_flush, fwdEn, ALU_cntrl};

  logic [9:0]  exp_ctl = '0;
  logic [63:0] exp_res = '0, exp_stb = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_mem(string nm);
    chk({nm, ".ctl"}, 64'({memToReg_MEM, memWrite_MEM, memRead_MEM,
        branchLink_MEM, RegWrite_MEM, targetReg_MEM}), 64'(exp_ctl));
    chk({nm, ".res"}, toDataMem_MEM, exp_res);
    chk({nm, ".stb"}, ALU_B_MEM, exp_stb);
  endtask

  task automatic dec(string nm, logic [10:0] op, logic sg,
                     logic [20:0] lit);
    opcode = op;
    sign = sg;
    #1;
    chk(nm, 64'(dec_act), 64'(lit));
    chk({nm, ".model"}, 64'(dec_act), 64'(model_dec(op, sg, rst)));
  endtask

  task automatic model_edge();
    if (rst) begin
      exp_ctl = {memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX,
                 RegWrite_EX, targetReg_EX};
      exp_res = toDataMem;
      exp_stb = ALU_B;
    end else begin
      exp_ctl = '0; exp_res = '0; exp_stb = '0;
    end
  endtask

  task automatic rand_ex();
    {memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX,
     RegWrite_EX} = 5'($urandom);
    targetReg_EX = 5'($urandom);
    toDataMem = {$urandom, $urandom};
    ALU_B = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rand_ex();
    toDataMem = 64'hDEAD_BEEF_0000_0001;
    ALU_B = '1;
    targetReg_EX = 5'd31;
    @(posedge clk);
    model_edge();
    #1 chk_mem("load_before_reset");
    opcode = 11'b10101011000;
    #1 rst = 1'b0;
    exp_ctl = '0; exp_res = '0; exp_stb = '0;
    #1 chk_mem("async_reset");
    chk("dec_in_reset", 64'(dec_act), 64'd0);
    #2 rst = 1'b1;
    {memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX} = '0;
    RegWrite_EX = 1'b1;
    targetReg_EX = 5'd5;
    toDataMem = 64'h10;
    ALU_B = '0;
    @(posedge clk);
    #1;
    chk("post_reset.tgt", 64'(targetReg_MEM), 64'd5);
    chk("post_reset.res", toDataMem_MEM, 64'h10);
    chk("post_reset.rw", 64'(RegWrite_MEM), 64'd1);

    dec("ADDS", 11'b10101011000, 0, 21'b0_0_1_0_1_0_0_0_0_0_0_1_1_0_0_0_11_010);
    dec("SUBS", 11'b11101011000, 0, 21'b0_0_1_0_1_0_0_0_0_0_0_1_1_0_0_0_11_011);
    dec("LSL", 11'b11010011011, 0, 21'b0_0_1_0_1_1_0_0_0_0_0_0_0_0_0_0_11_000);
    dec("LSR", 11'b11010011010, 1, 21'b0_0_1_0_1_1_0_0_0_0_1_0_0_0_0_0_11_000);
    dec("ADDI", 11'b10010001001, 0, 21'b0_0_0_1_1_0_1_0_0_0_0_1_0_0_0_0_10_010);
    dec("LDUR_n", 11'b11111000010, 1, 21'b0_0_0_1_1_0_0_1_0_1_0_1_0_0_0_0_00_011);
    dec("LDUR_p", 11'b11111000010, 0, 21'b0_0_0_1_1_0_0_1_0_1_0_1_0_0_0_0_00_010);
    dec("STUR", 11'b11111000000, 0, 21'b0_0_0_1_0_0_0_0_1_0_0_1_0_0_0_0_00_010);
    dec("B", 11'b00010100000, 0, 21'b1_1_0_0_0_0_0_0_0_0_0_0_0_0_0_1_00_000);
    dec("BL", 11'b10010100000, 1, 21'b1_1_0_0_1_0_0_0_0_0_0_1_0_0_1_1_00_000);
    dec("BR", 11'b11010110000, 0, 21'b1_1_0_0_0_0_0_0_0_0_0_0_0_1_0_1_00_000);
    dec("CBZ", 11'b10110100111, 1, 21'b0_1_0_0_0_0_0_0_0_0_0_1_0_0_0_1_00_000);
    dec("BCOND", 11'b01010100000, 0, 21'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_1_00_000);
    dec("NOP", 11'b00000000000, 1, 21'd0);

    begin
      logic [63:0] vals[3] = '{64'h1, '1, 64'h8000_0000_0000_0000};
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1 ALU_B = vals[i];
        if (i > 0) chk("stream", ALU_B_MEM, vals[i-1]);
      end
      @(posedge clk);
      #1 chk("stream_last", ALU_B_MEM, vals[2]);
    end

    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      model_edge();
      #1 chk_mem("rand_edge");
      rand_ex();
      if ($urandom_range(0, 3) != 0) begin
        int i = $urandom_range(0, 13);
        logic [10:0] msk = 11'((1 << (11 - t_len[i])) - 1);
        opcode = t_pat[i] | (11'($urandom) & msk);
      end else begin
        opcode = 11'($urandom);
      end
      sign = 1'($urandom);
      rst = ($urandom_range(0, 19) != 0);
      if (!rst) begin
        exp_ctl = '0; exp_res = '0; exp_stb = '0;
      end
      #1 chk_mem("rand_mid");
      chk("rand_dec", 64'(dec_act), 64'(model_dec(opcode, sign, rst)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
